// File: rtl/multdiv_wb_unit.sv
// Iterative signed multiply/divide unit feeding the register file write port.
// Define MULTDIV_STATUS_REDIRECT_EN to redirect exceptions to the status register.
module multdiv_wb_unit #(
  parameter int unsigned WIDTH      = 32,
  parameter logic [4:0]  STATUS_REG = 5'd30
) (
  input  logic             clock,
  input  logic             ctrl_reset_n,
  input  logic             ctrl_start,
  input  logic             ctrl_op,
  input  logic [4:0]       ctrl_rd,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic             busy,
  output logic             wb_writeEnable,
  output logic [4:0]       wb_writeReg,
  output logic [WIDTH-1:0] wb_data,
  output logic             data_exception
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StMult, StDiv, StWb} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [4:0]        rd_q, rd_d;
  logic              neg_q, neg_d;
  logic              dovf_q, dovf_d;
  logic              dz_q, dz_d;
  logic [WIDTH-1:0]  dsr_q, dsr_d;  // multiplicand or divisor magnitude
  logic [WIDTH-1:0]  hi_q, hi_d;    // product high half or partial remainder
  logic [WIDTH-1:0]  lo_q, lo_d;    // multiplier or dividend, becomes product low / quotient
  logic              busy_q, busy_d;
  logic              we_q, we_d;
  logic [4:0]        wreg_q, wreg_d;
  logic [WIDTH-1:0]  wdata_q, wdata_d;
  logic              exc_q, exc_d;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     msum;
  logic [WIDTH:0]     trial;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quot_s;
  logic               fin, fin_exc, fin_div;
  logic [WIDTH-1:0]   fin_res;

  always_comb begin
    mag_a  = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    mag_b  = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    msum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? dsr_q : '0)};
    trial  = {hi_q, lo_q[WIDTH-1]} - {1'b0, dsr_q};
    prod_s = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    quot_s = neg_q ? -lo_q : lo_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    neg_d   = neg_q;
    dovf_d  = dovf_q;
    dz_d    = dz_q;
    dsr_d   = dsr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    we_d    = 1'b0;
    wreg_d  = '0;
    wdata_d = '0;
    exc_d   = 1'b0;
    fin     = 1'b0;
    fin_exc = 1'b0;
    fin_div = 1'b0;
    fin_res = '0;

    unique case (state_q)
      StIdle: begin
        if (ctrl_start) begin
          state_d = ctrl_op ? StDiv : StMult;
          cnt_d   = '0;
          rd_d    = ctrl_rd;
          neg_d   = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
          dz_d    = ctrl_op && (data_operandB == '0);
          dovf_d  = ctrl_op && (data_operandA == {1'b1, {(WIDTH-1){1'b0}}})
                    && (data_operandB == '1);
          dsr_d   = ctrl_op ? mag_b : mag_a;
          hi_d    = '0;
          lo_d    = ctrl_op ? mag_a : mag_b;
        end
      end
      StMult: begin
        if (cnt_q == CntW'(WIDTH)) begin
          fin     = 1'b1;
          fin_res = prod_s[WIDTH-1:0];
          fin_exc = prod_s != {{WIDTH{prod_s[WIDTH-1]}}, prod_s[WIDTH-1:0]};
        end else begin
          {hi_d, lo_d} = {msum, lo_q[WIDTH-1:1]};
          cnt_d        = cnt_q + CntW'(1);
        end
      end
      StDiv: begin
        fin_div = 1'b1;
        if (dz_q) begin
          fin     = 1'b1;
          fin_exc = 1'b1;
        end else if (cnt_q == CntW'(WIDTH)) begin
          fin     = 1'b1;
          fin_res = quot_s;
          fin_exc = dovf_q;
        end else begin
          hi_d  = trial[WIDTH] ? {hi_q[WIDTH-2:0], lo_q[WIDTH-1]} : trial[WIDTH-1:0];
          lo_d  = {lo_q[WIDTH-2:0], ~trial[WIDTH]};
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWb: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
      default: state_d = StIdle;
    endcase

    if (fin) begin
      state_d = StWb;
      exc_d   = fin_exc;
`ifdef MULTDIV_STATUS_REDIRECT_EN
      if (fin_exc) begin
        we_d    = 1'b1;
        wreg_d  = STATUS_REG;
        wdata_d = fin_div ? WIDTH'(2) : WIDTH'(1);
      end else begin
        we_d    = rd_q != 5'd0;
        wreg_d  = rd_q;
        wdata_d = fin_res;
      end
`else
      we_d    = rd_q != 5'd0;
      wreg_d  = rd_q;
      wdata_d = fin_res;
`endif
    end

    busy_d = state_d != StIdle;
  end

  always_ff @(posedge clock) begin
    if (!ctrl_reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rd_q    <= '0;
      neg_q   <= 1'b0;
      dovf_q  <= 1'b0;
      dz_q    <= 1'b0;
      dsr_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      we_q    <= 1'b0;
      wreg_q  <= '0;
      wdata_q <= '0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      neg_q   <= neg_d;
      dovf_q  <= dovf_d;
      dz_q    <= dz_d;
      dsr_q   <= dsr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      we_q    <= we_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
      exc_q   <= exc_d;
    end
  end

  assign busy           = busy_q;
  assign wb_writeEnable = we_q;
  assign wb_writeReg    = wreg_q;
  assign wb_data        = wdata_q;
  assign data_exception = exc_q;

endmodule

// File: tb/tb_multdiv_wb_unit.sv
// Scoreboard bench for multdiv_wb_unit; honours MULTDIV_STATUS_REDIRECT_EN like the RTL.
module tb_multdiv_wb_unit;

  logic        clock = 1'b0;
  logic        ctrl_reset_n;
  logic        ctrl_start;
  logic        ctrl_op;
  logic [4:0]  ctrl_rd;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        busy;
  logic        wb_writeEnable;
  logic [4:0]  wb_writeReg;
  logic [31:0] wb_data;
  logic        data_exception;

  multdiv_wb_unit dut (
    .clock          (clock),
    .ctrl_reset_n   (ctrl_reset_n),
    .ctrl_start     (ctrl_start),
    .ctrl_op        (ctrl_op),
    .ctrl_rd        (ctrl_rd),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .busy           (busy),
    .wb_writeEnable (wb_writeEnable),
    .wb_writeReg    (wb_writeReg),
    .wb_data        (wb_data),
    .data_exception (data_exception)
  );

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    bit          we;
    logic [4:0]  rg;
    logic [31:0] data;
    bit          exc;
    int unsigned at;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain signed arithmetic from the operation rules.
  task automatic model(input bit op, input logic [4:0] rd, input logic [31:0] a,
                       input logic [31:0] b, output exp_t e, output int unsigned lat);
    longint      p;
    bit          exc;
    logic [31:0] res;
    logic [31:0] code;
    lat = 33;
    if (!op) begin
      p    = longint'($signed(a)) * longint'($signed(b));
      res  = p[31:0];
      exc  = p != longint'($signed(res));
      code = 32'd1;
    end else begin
      code = 32'd2;
      if (b == 32'd0) begin
        exc = 1'b1;
        res = 32'd0;
        lat = 1;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        exc = 1'b1;
        res = 32'h8000_0000;
      end else begin
        exc = 1'b0;
        res = $signed(a) / $signed(b);
      end
    end
    e.exc = exc;
`ifdef MULTDIV_STATUS_REDIRECT_EN
    if (exc) begin
      e.we   = 1'b1;
      e.rg   = 5'd30;
      e.data = code;
    end else begin
      e.we   = rd != 5'd0;
      e.rg   = rd;
      e.data = res;
    end
`else
    e.we   = rd != 5'd0;
    e.rg   = rd;
    e.data = res;
    if (code == 32'd0) e.data = 32'd0;
`endif
  endtask

  // Monitor: every writeback-cycle output must match the oldest expectation.
  always @(negedge clock) begin
    if (wb_writeEnable === 1'b1 || data_exception === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_wb", {wb_writeEnable, wb_writeReg, wb_data, data_exception}, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.we)
          check("wb_fields", {wb_writeEnable, wb_writeReg, wb_data, data_exception},
                {e.we, e.rg, e.data, e.exc});
        else
          check("wb_flags", {wb_writeEnable, data_exception}, {e.we, e.exc});
        check("wb_cycle", cyc, e.at);
      end
    end
  end

  task automatic issue(input bit op, input logic [4:0] rd, input logic [31:0] a,
                       input logic [31:0] b, input bit track, output int unsigned e0,
                       output int unsigned lat);
    exp_t e;
    int   n = 0;
    while (busy && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (busy) check("idle_timeout", busy, 0);
    ctrl_start    = 1'b1;
    ctrl_op       = op;
    ctrl_rd       = rd;
    data_operandA = a;
    data_operandB = b;
    model(op, rd, a, b, e, lat);
    @(posedge clock);
    #1;
    e0   = cyc;
    e.at = e0 + lat;
    if (track && (e.we || e.exc)) sb.push_back(e);
    @(negedge clock);
    ctrl_start    = 1'b0;
    ctrl_rd       = 5'($urandom);
    data_operandA = $urandom;
    data_operandB = $urandom;
    check("busy_rise", busy, 1);
  endtask

  task automatic run(input bit op, input logic [4:0] rd, input logic [31:0] a,
                     input logic [31:0] b);
    int unsigned e0, lat;
    int          n = 0;
    issue(op, rd, a, b, 1'b1, e0, lat);
    while (busy && n < 60) begin
      @(negedge clock);
      n++;
    end
    check("busy_fall_cycle", cyc, e0 + lat + 1);
  endtask

  function automatic logic [31:0] pick();
    unique case ($urandom_range(0, 4))
      0: return 32'($urandom_range(0, 2000)) - 32'd1000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 3));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int unsigned e0, lat;
    int          n;
    ctrl_reset_n  = 1'b0;
    ctrl_start    = 1'b0;
    ctrl_op       = 1'b0;
    ctrl_rd       = 5'd0;
    data_operandA = 32'd0;
    data_operandB = 32'd0;
    repeat (3) @(negedge clock);
    check("reset_outputs", {busy, wb_writeEnable, wb_writeReg, wb_data, data_exception}, 0);
    ctrl_reset_n = 1'b1;
    @(negedge clock);

    run(1'b0, 5'd5, 32'd7, -32'sd6);
    run(1'b1, 5'd9, -32'sd100, 32'd7);
    run(1'b1, 5'd9, 32'h8000_0000, 32'hFFFF_FFFF);
    run(1'b0, 5'd4, 32'h0001_0000, 32'h0001_0000);
    run(1'b1, 5'd3, 32'd12, 32'd0);
    run(1'b0, 5'd0, 32'd3, 32'd4);
    run(1'b1, 5'd0, 32'd5, 32'd0);

    // Starts during a running multiply and during its WB cycle must be dropped.
    issue(1'b0, 5'd7, 32'd3, 32'd5, 1'b1, e0, lat);
    repeat (9) @(negedge clock);
    ctrl_start = 1'b1; ctrl_op = 1'b1; ctrl_rd = 5'd8;
    data_operandA = 32'd40; data_operandB = 32'd0;
    @(negedge clock);
    ctrl_start = 1'b0;
    n = 0;
    while (!wb_writeEnable && n < 60) begin
      @(negedge clock);
      n++;
    end
    check("wb_seen", wb_writeEnable, 1);
    ctrl_start = 1'b1; ctrl_op = 1'b0; ctrl_rd = 5'd11;
    @(negedge clock);
    ctrl_start = 1'b0;
    check("busy_after_wb", busy, 0);
    @(negedge clock);
    check("start_in_wb_dropped", busy, 0);

    // Reset in the middle of a divide aborts it with no writeback.
    issue(1'b1, 5'd6, 32'd1000, 32'd7, 1'b0, e0, lat);
    repeat (19) @(negedge clock);
    ctrl_reset_n = 1'b0;
    @(negedge clock);
    ctrl_reset_n = 1'b1;
    check("abort_outputs", {busy, wb_writeEnable, wb_writeReg, wb_data, data_exception}, 0);
    repeat (40) @(negedge clock);

    for (int i = 0; i < 40; i++) begin
      run(1'($urandom), 5'($urandom), pick(), pick());
    end

    repeat (10) @(negedge clock);
    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
